// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
// The line is 32 bytes, filled as four 64-bit beats.
package icache_types;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2
  } state_t;

  localparam int BEATS       = 4;
  localparam int BEAT_BITS   = 64;
  localparam int LINE_BITS   = 256;
  localparam int OFFSET_BITS = 5;

  function automatic int idx_width(input int num_sets);
    return (num_sets > 1) ? $clog2(num_sets) : 1;
  endfunction

  function automatic int tag_width(input int num_sets);
    return 32 - OFFSET_BITS - idx_width(num_sets);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/line storage: asynchronous read, synchronous single-set write.
// Only the valid bits are reset; tag and data are don't-care until valid.
module icache_array
  import icache_types::*;
#(
  parameter int NUM_SETS = 8,
  parameter int IDX_W    = idx_width(NUM_SETS),
  parameter int TAG_W    = tag_width(NUM_SETS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic                 rd_vld,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [LINE_BITS-1:0] rd_dat,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [LINE_BITS-1:0] wr_dat
);

  logic [NUM_SETS-1:0]  valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_SETS];
  logic [LINE_BITS-1:0] data_q [NUM_SETS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_dat;
    end
  end

  assign rd_vld = valid_q[rd_idx];
  assign rd_tag = tag_q[rd_idx];
  assign rd_dat = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: 0-cycle combinational hit,
// miss fetches a 4-beat line and holds inst_mem_resp low until it is installed.
module icache
  import icache_types::*;
#(
  parameter int NUM_SETS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_mem_read,
  input  logic [31:0] inst_mem_address,
  output logic [31:0] inst_mem_rdata,
  output logic        inst_mem_resp,
  output logic        pmem_read,
  output logic [31:0] pmem_address,
  input  logic [63:0] pmem_rdata,
  input  logic        pmem_resp,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IDX_W = idx_width(NUM_SETS);
  localparam int TAG_W = tag_width(NUM_SETS);

  state_t               state_q, state_d;
  logic [1:0]           beat_q;
  logic [LINE_BITS-1:0] line_q;
  logic [31:0]          pmem_addr_q;
  logic [31:0]          hit_cnt_q;
  logic [31:0]          miss_cnt_q;

  logic [IDX_W-1:0]     addr_idx;
  logic [TAG_W-1:0]     addr_tag;
  logic [2:0]           word_sel;
  logic                 rd_vld;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_dat;
  logic                 hit;
  logic                 miss_start;
  logic                 beat_vld;
  logic                 unused_addr;

  assign addr_idx    = inst_mem_address[OFFSET_BITS +: IDX_W];
  assign addr_tag    = inst_mem_address[31 -: TAG_W];
  assign word_sel    = inst_mem_address[4:2];
  assign unused_addr = ^inst_mem_address[1:0];

  icache_array #(
    .NUM_SETS (NUM_SETS),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (addr_idx),
    .rd_vld (rd_vld),
    .rd_tag (rd_tag),
    .rd_dat (rd_dat),
    .wr_en  (state_q == FILL),
    .wr_idx (pmem_addr_q[OFFSET_BITS +: IDX_W]),
    .wr_tag (pmem_addr_q[31 -: TAG_W]),
    .wr_dat (line_q)
  );

  // Hits are only reported from IDLE so a redirect mid-miss never sees a half-built line.
  assign hit        = inst_mem_read && (state_q == IDLE) && rd_vld && (rd_tag == addr_tag);
  assign miss_start = inst_mem_read && (state_q == IDLE) && !hit;
  assign beat_vld   = (state_q == FETCH) && pmem_resp;

  assign inst_mem_resp  = hit;
  assign inst_mem_rdata = rd_dat[{word_sel, 5'b0} +: 32];
  assign pmem_read      = (state_q == FETCH);
  assign pmem_address   = pmem_addr_q;
  assign hit_count      = hit_cnt_q;
  assign miss_count     = miss_cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss_start) state_d = FETCH;
      FETCH:   if (beat_vld && (beat_q == 2'd3)) state_d = FILL;
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      beat_q      <= 2'd0;
      pmem_addr_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (miss_start) begin
        pmem_addr_q <= {inst_mem_address[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        beat_q      <= 2'd0;
      end else if (beat_vld) begin
        beat_q <= beat_q + 2'd1;
      end
      if (hit && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss_start && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  // The assembly buffer needs no reset: it is only written back after all four beats land.
  always_ff @(posedge clk) begin
    if (beat_vld) line_q[{beat_q, 6'b0} +: BEAT_BITS] <= pmem_rdata;
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: scoreboard of expected instruction words
// against a hashed burst-memory model with configurable inter-beat gaps.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_mem_read;
  logic [31:0] inst_mem_address;
  logic [31:0] inst_mem_rdata;
  logic        inst_mem_resp;
  logic        pmem_read;
  logic [31:0] pmem_address;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_hit  = 0;
  int          exp_miss = 0;
  int          mem_gap  = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  icache #(.NUM_SETS(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .inst_mem_read    (inst_mem_read),
    .inst_mem_address (inst_mem_address),
    .inst_mem_rdata   (inst_mem_rdata),
    .inst_mem_resp    (inst_mem_resp),
    .pmem_read        (pmem_read),
    .pmem_address     (pmem_address),
    .pmem_rdata       (pmem_rdata),
    .pmem_resp        (pmem_resp),
    .hit_count        (hit_count),
    .miss_count       (miss_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory: first beat one cycle after pmem_read rises, then one beat every (1+mem_gap) cycles.
  initial begin
    int age, beat, gap;
    age = 0; beat = 0; gap = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      pmem_resp  = 1'b0;
      pmem_rdata = {$urandom, $urandom};
      if (!pmem_read) begin
        age = 0; beat = 0; gap = 0;
      end else if (age == 0) begin
        age = 1;
      end else if (gap > 0) begin
        gap--;
      end else if (beat < 4) begin
        pmem_resp  = 1'b1;
        pmem_rdata = {mem_word(pmem_address + 32'(8*beat + 4)), mem_word(pmem_address + 32'(8*beat))};
        beat++;
        gap = mem_gap;
      end
    end
  end

  // Starts at a cycle boundary (posedge+1); returns after the response cycle has been clocked.
  task automatic fetch(input string tag, input logic [31:0] addr, input int exp_lat, input int n_miss,
                       input int redir_cyc, input logic [31:0] redir_addr,
                       output int rises, output logic [31:0] last_pa, output int first_cyc);
    int   lat;
    logic prev;
    bit   got;
    inst_mem_read    = 1'b1;
    inst_mem_address = addr;
    exp_q.push_back(mem_word(addr));
    rises = 0; last_pa = '0; first_cyc = -1; prev = 1'b0; got = 1'b0; lat = 40;
    for (int c = 0; c < 40; c++) begin
      if (c == redir_cyc) begin
        inst_mem_address = redir_addr;
        void'(exp_q.pop_back());
        exp_q.push_back(mem_word(redir_addr));
      end
      @(negedge clk);
      if (pmem_read && !prev) begin
        rises++;
        last_pa = pmem_address;
        if (first_cyc < 0) first_cyc = c;
      end
      prev = pmem_read;
      if (inst_mem_resp) begin
        check({tag, "_rdata"}, inst_mem_rdata, exp_q.pop_front());
        lat = c;
        got = 1'b1;
      end
      @(posedge clk);
      #1;
      if (got) break;
    end
    if (!got) void'(exp_q.pop_front());
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    exp_hit  += 1;
    exp_miss += n_miss;
  endtask

  initial begin
    int          r, fc, beats, rsum;
    logic [31:0] pa, hc0, mc0;
    bit          saw;
    rst = 1'b0;
    inst_mem_read = 1'b0;
    inst_mem_address = '0;
    #2;
    check("rst_resp", 32'(inst_mem_resp), 32'd0);
    check("rst_pmem_read", 32'(pmem_read), 32'd0);
    check("rst_pmem_addr", pmem_address, 32'd0);
    check("rst_hits", hit_count, 32'd0);
    check("rst_misses", miss_count, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // cold miss
    fetch("m60", 32'h60, 7, 1, -1, 32'h0, r, pa, fc);
    check("m60_pmem_cyc", 32'(fc), 32'd1);
    check("m60_pmem_addr", pa, 32'h60);
    check("m60_misses", miss_count, 32'(exp_miss));

    // rest of the line back to back
    rsum = 0;
    for (int a = 'h64; a <= 'h7C; a += 4) begin
      fetch("hit_line", 32'(a), 0, 0, -1, 32'h0, r, pa, fc);
      rsum += r;
    end
    check("hit_line_no_pmem", 32'(rsum), 32'd0);
    check("hit_line_hits", hit_count, 32'(exp_hit));

    // conflict on index 3, with unaligned byte offset
    fetch("m160", 32'h162, 7, 1, -1, 32'h0, r, pa, fc);
    check("m160_pmem_addr", pa, 32'h160);
    fetch("m60_again", 32'h60, 7, 1, -1, 32'h0, r, pa, fc);
    check("conflict_misses", miss_count, 32'(exp_miss));

    // redirect during FETCH: evict 0x60 first, then 0x60 -> 0x200 at cycle 3
    fetch("m160_b", 32'h160, 7, 1, -1, 32'h0, r, pa, fc);
    fetch("redir", 32'h60, 14, 2, 3, 32'h208, r, pa, fc);
    check("redir_rises", 32'(r), 32'd2);
    check("redir_pmem_addr", pa, 32'h200);
    fetch("redir_h60", 32'h7C, 0, 0, -1, 32'h0, r, pa, fc);
    check("redir_misses", miss_count, 32'(exp_miss));
    check("redir_hits", hit_count, 32'(exp_hit));

    // idle with valid lines
    hc0 = hit_count; mc0 = miss_count; saw = 1'b0;
    inst_mem_read = 1'b0;
    inst_mem_address = 32'h60;
    repeat (4) begin
      @(negedge clk);
      if (inst_mem_resp || pmem_read) saw = 1'b1;
      @(posedge clk); #1;
    end
    check("idle_quiet", 32'(saw), 32'd0);
    check("idle_hits", hit_count, hc0);
    check("idle_misses", miss_count, mc0);

    // reset after beat 1 of a miss
    inst_mem_read = 1'b1;
    inst_mem_address = 32'hA0;
    beats = 0;
    for (int c = 0; c < 20 && beats < 2; c++) begin
      @(negedge clk);
      if (pmem_resp && pmem_read) beats++;
      if (beats < 2) begin @(posedge clk); #1; end
    end
    check("rst_mid_beats", 32'(beats), 32'd2);
    @(posedge clk); #2;
    rst = 1'b0;
    inst_mem_read = 1'b0;
    #1;
    check("rst_mid_pmem_read", 32'(pmem_read), 32'd0);
    check("rst_mid_misses", miss_count, 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("rel_hits", hit_count, 32'd0);
    check("rel_misses", miss_count, 32'd0);
    exp_hit = 0; exp_miss = 0;
    fetch("rel_m60", 32'h60, 7, 1, -1, 32'h0, r, pa, fc);
    check("rel_m60_misses", miss_count, 32'(exp_miss));

    // one idle cycle between each beat pair: three cycles later overall
    mem_gap = 1;
    fetch("gap", 32'h1F4, 10, 1, -1, 32'h0, r, pa, fc);
    mem_gap = 0;
    fetch("gap_hit", 32'h1E0, 0, 0, -1, 32'h0, r, pa, fc);
    check("final_hits", hit_count, 32'(exp_hit));
    check("final_misses", miss_count, 32'(exp_miss));
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the pipelined datapath's instruction port and a 64-bit burst memory port. On a hit it returns the instruction in the same cycle as the address, so the IF/ID registers can capture it together with the PC. On a miss it fetches the 32-byte line in four beats, installs it, and then hits. While a miss is in progress, `inst_mem_resp` stays low, which drives the datapath's `inst_stall`.

## Interface
- `NUM_SETS`, default 8: number of lines; power of two; index width is log2(`NUM_SETS`).
- `clk`, input, 1: single clock; all state is updated on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset (asserted when 0).
- `inst_mem_read`, input, 1: fetch request.
- `inst_mem_address`, input, 32: byte address; bits [1:0] are ignored.
- `inst_mem_rdata`, output, 32: instruction word; valid only while `inst_mem_resp` is 1.
- `inst_mem_resp`, output, 1: hit indication; combinational from the current address.
- `pmem_read`, output, 1: burst read request.
- `pmem_address`, output, 32: line-aligned burst address (bits [4:0] are 0).
- `pmem_rdata`, input, 64: burst beat data.
- `pmem_resp`, input, 1: one pulse per valid beat.
- `hit_count`, output, 32: saturating count of hit cycles.
- `miss_count`, output, 32: saturating count of misses started.

## Operation
- Address fields:
  - offset: [4:0], word select [4:2]
  - index: [4+log2(`NUM_SETS`):5]
  - tag: the remaining upper bits
- Hit = `inst_mem_read` & state IDLE & valid[index] & tag match.
  - On a hit, `inst_mem_rdata` = word[addr[4:2]] of the line.
  - In any other case `inst_mem_rdata` is don't-care; drive it from the array anyway.
- **IDLE:** on `inst_mem_read` & !hit:
  - latch the line address into `pmem_address`;
  - clear the beat counter;
  - increment `miss_count`;
  - go to FETCH.
- **FETCH:**
  - `pmem_read` = 1; `pmem_address` is held stable.
  - Each cycle with `pmem_resp`=1 stores beat k into line bits [64k+63:64k] and increments the 2-bit beat counter.
  - On the beat with counter = 3, go to FILL.
- **FILL:**
  - `pmem_read` = 0.
  - Write the data, the tag, and valid = 1 into the set given by the latched address.
  - Go to IDLE.
- Address change mid-miss (squash or redirect): the fill always completes for the latched line. The new address is then evaluated in IDLE and may start a second miss.
- `pmem_resp` seen outside FETCH is ignored.
- Counters:
  - `hit_count` increments on every cycle where hit is true.
  - Both counters saturate at 0xFFFFFFFF.
- No writes from the datapath side; self-modifying code is unsupported.

## Timing
- Hit latency: 0 cycles. Resp and data are combinational, and the array read is asynchronous.
- Miss timeline (cycle 0 = miss seen in IDLE, beats returned on consecutive cycles):
  - cycle 1: `pmem_read` rises.
  - cycles 2–5: beats arrive.
  - cycle 6: FILL.
  - cycle 7: `inst_mem_resp` = 1.
- Memory stalls between beats simply extend FETCH.
- `pmem_read` stays high from the first FETCH cycle through the cycle of the 4th `pmem_resp`, and is low in FILL.
- Reset values (immediate on `rst`=0, independent of `clk`):
  - state IDLE; all valid bits 0; beat counter 0; counters 0
  - `pmem_read` = 0; `pmem_address` = 0; `inst_mem_resp` = 0
- Reset asserted mid-burst:
  - the burst is abandoned and no line is installed;
  - the memory side must tolerate `pmem_read` dropping mid-burst.
- Reset deassertion: the first hit is possible only after a full miss.

## Structure
- Package `icache_types`:
  - state enum {IDLE, FETCH, FILL}
  - `BEATS` = 4, `LINE_BITS` = 256, `OFFSET_BITS` = 5
  - index and tag width functions of `NUM_SETS`
- Sub-module `icache_array`: valid/tag/256-bit data storage with asynchronous read and a synchronous single-set write port. It is cleared by `rst`; only the valid bits need resetting.
- Top level: FSM, beat counter, line assembly register, hit logic, counters.

## Test plan
- After reset, read 0x00000060 with a 4-beat memory:
  - miss in cycle 0; `pmem_read`=1 with `pmem_address`=0x00000060 in cycle 1;
  - `inst_mem_resp`=1 in cycle 7, rdata = low word of beat 0;
  - `miss_count`=1.
- Read 0x64, 0x68, …, 0x7C back to back after that fill:
  - resp=1 on every cycle, each word taken from the correct beat half;
  - `pmem_read` stays 0; `hit_count` increments by 7.
- Conflict, with `NUM_SETS`=8: read 0x160 (index 3, different tag) → miss and refill; a subsequent read of 0x60 misses again.
- Change the address from 0x60 to 0x200 during FETCH:
  - the 0x60 line is installed;
  - 0x200 then misses with `pmem_address`=0x200;
  - a later read of 0x60 hits.
- Assert `rst`=0 after beat 1:
  - `pmem_read` drops asynchronously;
  - after release, 0x60 misses again and the counters read 0.
- Hold `inst_mem_read`=0 with valid lines present: resp=0, no `pmem_read`, counters unchanged. Insert 3 idle cycles between beats: fill is still correct and resp comes 3 cycles later.
